alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and at least 8.
REQ-002 SHALL have port CLOCK_IN, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_IN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports Start_IN (input, 1, request strobe), Flush_IN (input, 1, abort) and Op_IN (input, 3, operation select).
REQ-005 SHALL have ports OperandA_IN and OperandB_IN, input, WIDTH each, operands sampled only on the acceptance edge.
REQ-006 SHALL have outputs Busy_OUT (1), Done_OUT (1, one-cycle pulse), DivZero_OUT (1, one-cycle pulse), HI_OUT and LO_OUT (WIDTH each, architectural HI/LO).

Function
REQ-007 Op_IN encodings SHALL be 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
REQ-008 Start_IN SHALL be accepted on a rising edge only when Busy_OUT=0 and Flush_IN=0; otherwise it SHALL be ignored with no side effects.
REQ-009 FSM states SHALL be IDLE, CALC, FIX; Busy_OUT=1 exactly in CALC and FIX.
REQ-010 MTHI/MTLO SHALL write OperandA_IN to HI/LO on the acceptance edge, stay in IDLE, and pulse Done_OUT in the following cycle.
REQ-011 DIV/DIVU with OperandB_IN=0 SHALL leave HI/LO unchanged, stay in IDLE, and pulse Done_OUT and DivZero_OUT together in the following cycle.
REQ-012 Other accepted ops SHALL go IDLE->CALC, run WIDTH CALC iterations (one bit per edge), then go CALC->FIX and FIX->IDLE.
REQ-013 The FIX edge SHALL write HI/LO, and Done_OUT SHALL be high for exactly the one cycle following it; latency is WIDTH+1 edges after acceptance (33 at WIDTH=32).
REQ-014 MULT/MULTU SHALL set {HI,LO} to the 2*WIDTH-bit signed/unsigned product.
REQ-015 MADD/MSUB SHALL set {HI,LO} to {HI,LO} plus/minus the signed product, modulo 2^(2*WIDTH).
REQ-016 DIV/DIVU SHALL set LO=quotient and HI=remainder; signed quotients truncate toward zero and the remainder takes the dividend's sign.
REQ-017 DIV of most-negative by -1 SHALL give LO=most-negative and HI=0, with no flag.
REQ-018 Flush_IN=1 SHALL return the FSM to IDLE on the next edge from any state, leave HI/LO unchanged, and suppress Done_OUT; Flush_IN SHALL win over a simultaneous Start_IN.
REQ-019 HI_OUT/LO_OUT SHALL be driven directly from registers and change only on MTHI/MTLO, FIX edges, or reset.

Reset
REQ-020 Asserting RESET_IN SHALL immediately force: FSM to IDLE; HI_OUT, LO_OUT, internal accumulators and counter to 0; Busy_OUT, Done_OUT and DivZero_OUT to 0.
REQ-021 Reset during CALC/FIX SHALL abandon the operation, with no Done_OUT after release.
REQ-022 The first Start_IN SHALL be accepted on the first rising edge after RESET_IN deasserts.

Configuration
REQ-023 Macro MDU_FAST_MUL_EN defined: MULT/MULTU/MADD/MSUB SHALL compute the product combinationally, go IDLE->FIX directly, and complete with latency 2 edges after acceptance.
REQ-024 Macro MDU_FAST_MUL_EN undefined: multiplies SHALL use the iterative shift-add path of REQ-012; division timing is identical in both builds.

Structure
REQ-025 Shared package mdu_pkg SHALL hold the Op_IN encoding constants, the FSM state encoding, and the default WIDTH constant.
REQ-026 The iterative restoring divider (magnitude datapath, counter-driven) SHALL be sub-module mdu_divider; sign correction SHALL remain in alu_mdu's FIX state.

Verification (WIDTH=32)
REQ-027 DIV with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, Done_OUT exactly 33 edges after acceptance; DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-028 MULT with A=0xFFFFFFFF, B=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=1, LO=0xFFFFFFFE; run in both MDU_FAST_MUL_EN builds and check latency 2 vs 33.
REQ-029 MTLO 5, MTHI 0, then MADD with A=3, B=4 -> LO=17, HI=0; then MSUB with A=1, B=18 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
REQ-030 DIVU with A=5, B=0 and HI/LO preset 0xAA/0xBB -> DivZero_OUT and Done_OUT pulse next cycle, HI/LO unchanged, Busy_OUT never high.
REQ-031 Start DIV, assert Start_IN (MTHI) on CALC edge 5 and Flush_IN on CALC edge 10 -> MTHI ignored, Busy_OUT low after the flush edge, no Done_OUT, HI/LO unchanged.
REQ-032 Assert RESET_IN asynchronously mid-CALC -> outputs 0 immediately, no Done_OUT after release, new MULTU accepted on the first edge after release.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// state encoding and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes; one quotient bit per step.
// The parent loads operands, then asserts step once per iteration.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH:0]   shifted, trial;

  // Partial remainder stays below the divisor, so W bits hold it between steps.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// Multiply/divide unit with architectural HI/LO. Define MDU_FAST_MUL_EN for a
// single-cycle multiplier (registered once before FIX writes HI/LO).
//
// state   | meaning
// IDLE    | waiting for Start_IN; MTHI/MTLO and divide-by-zero finish here
// CALC    | WIDTH shift-add / restoring-divide iterations
// FIX     | sign correction, HI/LO write, Done_OUT on the next cycle
module alu_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             CLOCK_IN,
  input  logic             RESET_IN,
  input  logic             Start_IN,
  input  logic             Flush_IN,
  input  logic [2:0]       Op_IN,
  input  logic [WIDTH-1:0] OperandA_IN,
  input  logic [WIDTH-1:0] OperandB_IN,
  output logic             Busy_OUT,
  output logic             Done_OUT,
  output logic             DivZero_OUT,
  output logic [WIDTH-1:0] HI_OUT,
  output logic [WIDTH-1:0] LO_OUT
);

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  mdu_state_e         state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   mcand_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               neg_q, neg_rem_q, busy_q, done_q, dz_q;

  logic               accept, op_signed, is_div, is_div_q, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, div_quo, div_rem, quo_fix, rem_fix;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_signed, hilo_next;

  assign accept    = Start_IN && !Flush_IN && (state == ST_IDLE);
  assign op_signed = (Op_IN != OP_MULTU) && (Op_IN != OP_DIVU);
  assign is_div    = (Op_IN == OP_DIV) || (Op_IN == OP_DIVU);
  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign sa        = op_signed && OperandA_IN[WIDTH-1];
  assign sb        = op_signed && OperandB_IN[WIDTH-1];
  assign mag_a     = sa ? -OperandA_IN : OperandA_IN;
  assign mag_b     = sb ? -OperandB_IN : OperandB_IN;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (CLOCK_IN),
    .rst_n     (RESET_IN),
    .load      (accept),
    .step      ((state == ST_CALC) && is_div_q),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Shift-add: low half starts as the multiplier and drains out as the product fills in.
  assign add_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_signed = neg_q ? -prod_q : prod_q;
  assign quo_fix     = neg_q ? -div_quo : div_quo;
  assign rem_fix     = neg_rem_q ? -div_rem : div_rem;

  always_comb begin
    hilo_next = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: hilo_next = prod_signed;
      OP_MADD:           hilo_next = {hi_q, lo_q} + prod_signed;
      OP_MSUB:           hilo_next = {hi_q, lo_q} - prod_signed;
      OP_DIV, OP_DIVU:   hilo_next = {rem_fix, quo_fix};
      default:           hilo_next = {hi_q, lo_q};
    endcase
  end

  always_ff @(posedge CLOCK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      mcand_q   <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (Flush_IN) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (Op_IN == OP_MTHI) begin
                hi_q   <= OperandA_IN;
                done_q <= 1'b1;
              end else if (Op_IN == OP_MTLO) begin
                lo_q   <= OperandA_IN;
                done_q <= 1'b1;
              end else if (is_div && (OperandB_IN == '0)) begin
                done_q <= 1'b1;
                dz_q   <= 1'b1;
              end else begin
                op_q      <= Op_IN;
                neg_q     <= sa ^ sb;
                neg_rem_q <= sa;
                mcand_q   <= mag_a;
                prod_q    <= {{WIDTH{1'b0}}, mag_b};
                busy_q    <= 1'b1;
                if (FAST_MUL && !is_div) begin
                  state <= ST_FIX;
                  cnt   <= CW'(1);
                end else begin
                  state <= ST_CALC;
                  cnt   <= CW'(WIDTH);
                end
              end
            end
          end
          ST_CALC: begin
            cnt <= cnt - CW'(1);
            if (!is_div_q) prod_q <= {add_sum, prod_q[WIDTH-1:1]};
            if (cnt == CW'(1)) state <= ST_FIX;
          end
          ST_FIX: begin
            if (FAST_MUL && (cnt != '0)) begin
              cnt    <= '0;
              prod_q <= {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
            end else begin
              hi_q   <= hilo_next[2*WIDTH-1:WIDTH];
              lo_q   <= hilo_next[WIDTH-1:0];
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Busy_OUT    = busy_q;
  assign Done_OUT    = done_q;
  assign DivZero_OUT = dz_q;
  assign HI_OUT      = hi_q;
  assign LO_OUT      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32: directed vector table, flush and
// reset sequences, then random operations against a plain-arithmetic model.
module tb_alu_mdu;

  localparam int LAT_DIV = 33;
`ifdef MDU_FAST_MUL_EN
  localparam int LAT_MUL = 2;
`else
  localparam int LAT_MUL = 33;
`endif

  logic        CLOCK_IN = 1'b0;
  logic        RESET_IN;
  logic        Start_IN, Flush_IN;
  logic [2:0]  Op_IN;
  logic [31:0] OperandA_IN, OperandB_IN;
  logic        Busy_OUT, Done_OUT, DivZero_OUT;
  logic [31:0] HI_OUT, LO_OUT;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  alu_mdu #(.WIDTH(32)) dut (
    .CLOCK_IN    (CLOCK_IN),
    .RESET_IN    (RESET_IN),
    .Start_IN    (Start_IN),
    .Flush_IN    (Flush_IN),
    .Op_IN       (Op_IN),
    .OperandA_IN (OperandA_IN),
    .OperandB_IN (OperandB_IN),
    .Busy_OUT    (Busy_OUT),
    .Done_OUT    (Done_OUT),
    .DivZero_OUT (DivZero_OUT),
    .HI_OUT      (HI_OUT),
    .LO_OUT      (LO_OUT)
  );

  always #5 CLOCK_IN = ~CLOCK_IN;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: HI/LO as a 64-bit pair, products and quotients in 64-bit integers.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b, hi_in, lo_in,
                                output logic [31:0] hi_o, lo_o, output logic dz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hi_in, lo_in};
    dz  = 1'b0;
    lat = LAT_MUL;
    case (op)
      3'd0: acc = 64'(sa * sb);
      3'd1: acc = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        lat = LAT_DIV;
        if (b == 32'd0) begin
          dz  = 1'b1;
          lat = 0;
        end else if (op == 3'd2) begin
          q   = sa / sb;
          r   = sa % sb;
          acc = {r[31:0], q[31:0]};
        end else begin
          acc = {a % b, a / b};
        end
      end
      3'd4: acc = acc + 64'(sa * sb);
      3'd5: acc = acc - 64'(sa * sb);
      3'd6: begin acc[63:32] = a; lat = 0; end
      default: begin acc[31:0] = a; lat = 0; end
    endcase
    hi_o = acc[63:32];
    lo_o = acc[31:0];
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, eh, el,
                        input logic edz, input int elat, input string tag, input bit sync);
    int lat;
    if (sync) @(negedge CLOCK_IN);
    Op_IN = op; OperandA_IN = a; OperandB_IN = b; Start_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Start_IN = 1'b0; OperandA_IN = $urandom; OperandB_IN = $urandom;
    check({tag, " busy_after_accept"}, 64'(Busy_OUT), 64'(elat > 0));
    lat = 0;
    while (!Done_OUT && lat < 60) begin
      @(posedge CLOCK_IN); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " divzero"}, 64'(DivZero_OUT), 64'(edz));
    check({tag, " busy_at_done"}, 64'(Busy_OUT), 64'd0);
    check({tag, " hi"}, 64'(HI_OUT), 64'(eh));
    check({tag, " lo"}, 64'(LO_OUT), 64'(el));
    @(posedge CLOCK_IN); #1;
    check({tag, " done_one_cycle"}, 64'(Done_OUT), 64'd0);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"}, 64'(Busy_OUT), 64'd0);
    check({tag, " done"}, 64'(Done_OUT), 64'd0);
    check({tag, " divzero"}, 64'(DivZero_OUT), 64'd0);
    check({tag, " hi"}, 64'(HI_OUT), 64'd0);
    check({tag, " lo"}, 64'(LO_OUT), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eh, el;
    logic        edz, seen;
    int          elat;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0] = '{"div_neg7_2",     3'd2, 32'hFFFFFFF9, 32'd2,        32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT_DIV};
    vecs[1] = '{"div_minneg_m1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd9,  32'd9,  32'd0,        32'h80000000, 1'b0, LAT_DIV};
    vecs[2] = '{"mult_m1_2",      3'd0, 32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, LAT_MUL};
    vecs[3] = '{"multu_m1_2",     3'd1, 32'hFFFFFFFF, 32'd2,        32'd0,  32'd0,  32'd1,        32'hFFFFFFFE, 1'b0, LAT_MUL};
    vecs[4] = '{"madd_3_4",       3'd4, 32'd3,        32'd4,        32'd0,  32'd5,  32'd0,        32'd17,       1'b0, LAT_MUL};
    vecs[5] = '{"msub_1_18",      3'd5, 32'd1,        32'd18,       32'd0,  32'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, LAT_MUL};
    vecs[6] = '{"divu_by_zero",   3'd3, 32'd5,        32'd0,        32'hAA, 32'hBB, 32'hAA,       32'hBB,       1'b1, 0};
    vecs[7] = '{"div_7_neg2",     3'd2, 32'd7,        32'hFFFFFFFE, 32'd0,  32'd0,  32'd1,        32'hFFFFFFFD, 1'b0, LAT_DIV};
    vecs[8] = '{"divu_max_10",    3'd3, 32'hFFFFFFFF, 32'd10,       32'd0,  32'd0,  32'd5,        32'h19999999, 1'b0, LAT_DIV};
    vecs[9] = '{"div_by_zero",    3'd2, 32'd0,        32'd0,        32'd1,  32'd2,  32'd1,        32'd2,        1'b1, 0};

    RESET_IN = 1'b0; Start_IN = 1'b0; Flush_IN = 1'b0; Op_IN = 3'd0;
    OperandA_IN = 32'd0; OperandB_IN = 32'd0;
    #1;
    check_zero_outputs("reset_state");
    @(negedge CLOCK_IN); @(negedge CLOCK_IN);
    RESET_IN = 1'b1;

    foreach (vecs[i]) begin
      run_op(3'd6, vecs[i].pre_hi, 32'd0, vecs[i].pre_hi, m_lo, 1'b0, 0, {vecs[i].name, " preset_hi"}, 1'b1);
      run_op(3'd7, vecs[i].pre_lo, 32'd0, m_hi, vecs[i].pre_lo, 1'b0, 0, {vecs[i].name, " preset_lo"}, 1'b1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             vecs[i].exp_dz, vecs[i].exp_lat, vecs[i].name, 1'b1);
    end

    // Flush beats a simultaneous start in IDLE.
    @(negedge CLOCK_IN);
    Op_IN = 3'd6; OperandA_IN = 32'hDEAD; Start_IN = 1'b1; Flush_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Start_IN = 1'b0; Flush_IN = 1'b0;
    check("flush_vs_start done", 64'(Done_OUT), 64'd0);
    check("flush_vs_start hi", 64'(HI_OUT), 64'(m_hi));

    // DIV with an ignored MTHI on CALC edge 5 and a flush on CALC edge 10.
    @(negedge CLOCK_IN);
    Op_IN = 3'd2; OperandA_IN = 32'd100; OperandB_IN = 32'd3; Start_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Start_IN = 1'b0;
    check("flush_seq busy_after_accept", 64'(Busy_OUT), 64'd1);
    seen = 1'b0;
    repeat (4) begin @(posedge CLOCK_IN); #1; seen |= Done_OUT; end
    Op_IN = 3'd6; OperandA_IN = 32'h1234; Start_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Start_IN = 1'b0; seen |= Done_OUT;
    check("flush_seq busy_after_start_while_busy", 64'(Busy_OUT), 64'd1);
    repeat (4) begin @(posedge CLOCK_IN); #1; seen |= Done_OUT; end
    Flush_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Flush_IN = 1'b0; seen |= Done_OUT;
    check("flush_seq busy_after_flush", 64'(Busy_OUT), 64'd0);
    repeat (40) begin @(posedge CLOCK_IN); #1; seen |= Done_OUT; end
    check("flush_seq no_done", 64'(seen), 64'd0);
    check("flush_seq hi", 64'(HI_OUT), 64'(m_hi));
    check("flush_seq lo", 64'(LO_OUT), 64'(m_lo));

    // Asynchronous reset in the middle of CALC.
    run_op(3'd6, 32'h55, 32'd0, 32'h55, m_lo, 1'b0, 0, "rst_seq preset_hi", 1'b1);
    run_op(3'd7, 32'h66, 32'd0, m_hi, 32'h66, 1'b0, 0, "rst_seq preset_lo", 1'b1);
    @(negedge CLOCK_IN);
    Op_IN = 3'd3; OperandA_IN = 32'd1000; OperandB_IN = 32'd7; Start_IN = 1'b1;
    @(posedge CLOCK_IN); #1;
    Start_IN = 1'b0;
    repeat (10) @(posedge CLOCK_IN);
    #3 RESET_IN = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge CLOCK_IN); #1;
    check("async_reset held busy", 64'(Busy_OUT), 64'd0);
    @(negedge CLOCK_IN);
    RESET_IN = 1'b1;
    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, LAT_MUL, "multu_after_reset", 1'b0);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 4) == 0) b = 32'd0;
      if (op == 3'd2 && $urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
      model(op, a, b, m_hi, m_lo, eh, el, edz, elat);
      run_op(op, a, b, eh, el, edz, elat, $sformatf("rand%0d op%0d", n, op), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
